// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared EX-stage control types, forwarding encodings and selection helper
package mips_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } ex_state_t;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    // A load in EX/MEM has no data yet, so only its MEM/WB copy may forward.
    function automatic logic [1:0] fwd_select(
        input logic [4:0] src,
        input logic [4:0] exmem_rd,
        input logic       exmem_alu_write,
        input logic [4:0] memwb_rd,
        input logic       memwb_write
    );
        if (exmem_alu_write && exmem_rd != 5'd0 && exmem_rd == src)
            return FWD_EXMEM;
        if (memwb_write && memwb_rd != 5'd0 && memwb_rd == src)
            return FWD_MEMWB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/forward_unit.sv
// rtl/forward_unit.sv - combinational ALU operand source selection for both EX operands
module forward_unit
    import mips_ctrl_pkg::*;
(
    input  logic [4:0] ex_rs,
    input  logic [4:0] ex_rt,
    input  logic [4:0] exmem_rd,
    input  logic       exmem_reg_write,
    input  logic       exmem_is_load,
    input  logic [4:0] memwb_rd,
    input  logic       memwb_reg_write,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    logic exmem_alu_write;

    assign exmem_alu_write = exmem_reg_write && !exmem_is_load;
    assign fwd_a = fwd_select(ex_rs, exmem_rd, exmem_alu_write, memwb_rd, memwb_reg_write);
    assign fwd_b = fwd_select(ex_rt, exmem_rd, exmem_alu_write, memwb_rd, memwb_reg_write);

endmodule

// File: rtl/ex_hazard_controller.sv
// rtl/ex_hazard_controller.sv - EX-stage hazard, multi-cycle hold and cache-freeze sequencing
module ex_hazard_controller
    import mips_ctrl_pkg::*;
#(
    parameter int MC_LATENCY  = 4,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       ex_valid,
    input  logic [4:0] ex_rs,
    input  logic [4:0] ex_rt,
    input  logic [4:0] ex_rd,
    input  logic       ex_is_load,
    input  logic       ex_multicycle,
    input  logic       pc_src,
    input  logic [4:0] exmem_rd,
    input  logic       exmem_reg_write,
    input  logic       exmem_is_load,
    input  logic [4:0] memwb_rd,
    input  logic       memwb_reg_write,
    input  logic       mem_ready,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       stall_pc,
    output logic       stall_ifid,
    output logic       stall_idex,
    output logic       stall_exmem,
    output logic       stall_memwb,
    output logic       flush_ifid,
    output logic       bubble_idex,
    output logic       bubble_exmem,
    output logic       mc_start,
    output logic       mc_done,
    output logic       mem_timeout
);

    localparam int         WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
    localparam logic [3:0] MC_LOAD  = 4'(MC_LATENCY - 1);

    ex_state_t         state;
    logic [3:0]        mc_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [1:0]        fwd_a_raw;
    logic [1:0]        fwd_b_raw;
    logic              branch;
    logic              load_use;
    logic              mc_enter;

    forward_unit u_forward (
        .ex_rs           (ex_rs),
        .ex_rt           (ex_rt),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_is_load   (exmem_is_load),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .fwd_a           (fwd_a_raw),
        .fwd_b           (fwd_b_raw)
    );

    assign fwd_a    = rst_b ? fwd_a_raw : FWD_RF;
    assign fwd_b    = rst_b ? fwd_b_raw : FWD_RF;
    assign branch   = ex_valid && pc_src;
    assign mc_enter = ex_valid && ex_multicycle && !pc_src;
    assign load_use = ex_valid && ex_is_load && ex_rd != 5'd0 &&
                      (ex_rd == id_rs || ex_rd == id_rt);

    always_comb begin
        stall_pc     = 1'b0;
        stall_ifid   = 1'b0;
        stall_idex   = 1'b0;
        stall_exmem  = 1'b0;
        stall_memwb  = 1'b0;
        flush_ifid   = 1'b0;
        bubble_idex  = 1'b0;
        bubble_exmem = 1'b0;
        mc_start     = 1'b0;
        mc_done      = 1'b0;
        if (!rst_b) begin
            mc_done = 1'b0;
        end else if (!mem_ready) begin
            {stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb} = 5'b11111;
        end else if (state == MC_BUSY) begin
            if (mc_cnt > 4'd1)
                {stall_pc, stall_ifid, stall_idex, bubble_exmem} = 4'b1111;
            else
                mc_done = 1'b1;
        end else if (branch) begin
            flush_ifid  = 1'b1;
            bubble_idex = 1'b1;
        end else if (mc_enter) begin
            mc_start = 1'b1;
            {stall_pc, stall_ifid, stall_idex, bubble_exmem} = 4'b1111;
        end else if (load_use) begin
            {stall_pc, stall_ifid, bubble_idex} = 3'b111;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state       <= RUN;
            mc_cnt      <= 4'd0;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else if (!mem_ready) begin
            // Frozen: sequencing state holds, only the not-ready streak advances.
            if (wait_cnt != WAIT_MAX)
                wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt >= WAIT_MAX - 1'b1)
                mem_timeout <= 1'b1;
        end else begin
            wait_cnt <= '0;
            case (state)
                RUN: begin
                    if (mc_enter) begin
                        state  <= MC_BUSY;
                        mc_cnt <= MC_LOAD;
                    end
                end
                MC_BUSY: begin
                    if (mc_cnt > 4'd1) begin
                        mc_cnt <= mc_cnt - 4'd1;
                    end else begin
                        state  <= RUN;
                        mc_cnt <= 4'd0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: doc/ex_hazard_controller.md
Name: ex_hazard_controller

Overview:
Sequencing controller for the EX stage of the 5-stage MIPS pipeline.
- Selects ALU operand forwarding sources.
- Detects load-use hazards and flushes the front end on a taken branch resolved in EX.
- Holds EX for multi-cycle ALU ops (mult/div) and freezes the whole pipeline while the data cache is not ready.
- Drives the stall/flush/bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.

Parameters:
- MC_LATENCY, 4: cycles a multi-cycle op occupies EX; legal range 2..16.
- MEM_TIMEOUT, 64: consecutive not-ready cycles before mem_timeout is raised.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_b  in  1  synchronous reset, active-low.
- id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
- ex_valid  in  1  ID/EX holds a real instruction.
- ex_rs, ex_rt  in  5 each  source register numbers in EX.
- ex_rd  in  5  destination register number in EX (rd_num).
- ex_is_load  in  1  the instruction in EX is a load.
- ex_multicycle  in  1  the ALU_OP in EX is mult/div.
- pc_src  in  1  branch taken, resolved in EX.
- exmem_rd  in  5  destination register in EX/MEM.
- exmem_reg_write  in  1  EX/MEM writes a register.
- exmem_is_load  in  1  EX/MEM holds a load.
- memwb_rd  in  5  destination register in MEM/WB.
- memwb_reg_write  in  1  MEM/WB writes a register.
- mem_ready  in  1  cache can complete its access this cycle.
- fwd_a, fwd_b  out  2 each  operand source: 00 register file, 10 EX/MEM, 01 MEM/WB.
- stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb  out  1 each  hold the register.
- flush_ifid, bubble_idex, bubble_exmem  out  1 each  load a NOP.
- mc_start  out  1  one-cycle pulse that starts the multi-cycle unit.
- mc_done  out  1  multi-cycle result is valid this cycle.
- mem_timeout  out  1  sticky error flag.

Behaviour:
- Reset:
  - While rst_b is sampled low: state=RUN, mc_cnt=0, wait_cnt=0, mem_timeout=0.
  - During that cycle all stall/flush/bubble/mc outputs are 0 and fwd_a=fwd_b=00.
- States: RUN, MC_BUSY. Outputs are combinational from state, counters and inputs.
- Forwarding, per operand, rule for fwd_a (fwd_b identical using ex_rt):
  - 10 if exmem_reg_write && !exmem_is_load && exmem_rd!=0 && exmem_rd==ex_rs.
  - Else 01 if memwb_reg_write && memwb_rd!=0 && memwb_rd==ex_rs.
  - Else 00. EX/MEM has priority over MEM/WB.
- Freeze (mem_ready=0):
  - Assert all five stall_* outputs; flush/bubble/mc_start are 0.
  - mc_cnt holds and the state does not change.
  - pc_src and load-use are ignored this cycle and re-evaluated after release.
  - wait_cnt increments, saturating. When it reaches MEM_TIMEOUT, mem_timeout is set and stays set until reset.
  - wait_cnt clears on any cycle with mem_ready=1.
- Branch (RUN, mem_ready=1, ex_valid, pc_src): flush_ifid=1 and bubble_idex=1. It overrides load-use in the same cycle.
- Load-use (RUN, mem_ready=1, no branch, ex_valid && ex_is_load && ex_rd!=0 && (ex_rd==id_rs || ex_rd==id_rt)):
  - stall_pc=1, stall_ifid=1, bubble_idex=1 for exactly one cycle.
- Multi-cycle op, entered in EX at cycle T in RUN with ex_valid && ex_multicycle && mem_ready:
  - At T: mc_start=1, mc_cnt is loaded with MC_LATENCY-1, next state MC_BUSY.
  - At T and in every MC_BUSY cycle with mc_cnt>1: stall_pc, stall_ifid, stall_idex, bubble_exmem; mc_cnt decrements.
  - In MC_BUSY with mc_cnt==1: mc_done=1, no stalls, EX/MEM captures the result, next state RUN.
  - The op occupies EX for exactly MC_LATENCY cycles.
  - pc_src is not evaluated while in MC_BUSY. A mult/div is never a branch.
- A multi-cycle op with pc_src asserted is illegal; the verification engineer asserts against it.
- A reset mid-MC_BUSY aborts the op: state RUN, no mc_done.
- Register number 0 never matches for forwarding or load-use.

Decomposition:
- Shared package mips_ctrl_pkg:
  - typedef ex_state_t {RUN, MC_BUSY}.
  - Forwarding encodings FWD_RF=2'b00, FWD_EXMEM=2'b10, FWD_MEMWB=2'b01.
- One sub-module, forward_unit: purely combinational forwarding selection. It is instantiated once and produces both fwd_a and fwd_b.
- Stall/flush sequencing, both counters and the state register stay in ex_hazard_controller.

Test Plan:
- Forwarding:
  - Stimulus: exmem_rd=5 (reg_write=1, not load), memwb_rd=5 (reg_write=1), ex_rs=5, ex_rt=5.
    Required response: fwd_a=10, fwd_b=10.
  - Stimulus: the same with exmem_reg_write dropped.
    Required response: fwd_a=fwd_b=01.
  - Stimulus: rd=0 on both stages.
    Required response: 00.
- Load-use:
  - Stimulus: ex_is_load, ex_rd=8, id_rt=8.
    Required response: one cycle of stall_pc=stall_ifid=bubble_idex=1, then all 0.
  - Stimulus: add pc_src=1 in the same cycle.
    Required response: flush_ifid=bubble_idex=1, stall_pc=0.
- Multi-cycle with MC_LATENCY=4:
  - Stimulus: ex_multicycle at T.
    Required response: mc_start at T only; stalls and bubble_exmem at T..T+2; mc_done at T+3 with no stall.
- Freeze during MC_BUSY:
  - Stimulus: mem_ready=0 for 2 cycles at T+1.
    Required response: all five stalls high; mc_done delayed to T+5.
- Timeout with MEM_TIMEOUT=64:
  - Stimulus: mem_ready held low for 64 cycles.
    Required response: mem_timeout=1 and sticky after mem_ready returns.
  - Stimulus: rst_b=0 for one cycle.
    Required response: mem_timeout cleared.
- Reset mid-op:
  - Stimulus: rst_b=0 at T+1 of a multi-cycle op.
    Required response: next cycle in RUN, all outputs 0, mc_done never asserted.
